// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sync_fifo_pkg;
   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_DEPTH_BIT = 3;
endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array, D x WIDTH, for the synchronous FIFO.
// Latency: write lands on the edge; read data is registered, one edge after rd_en_i.
// Backpressure: none; the caller decides which accesses are legal.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH_BIT = DEFAULT_DEPTH_BIT
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 wr_en_i,
   input  logic [DEPTH_BIT-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]     wr_data_i,
   input  logic                 rd_en_i,
   input  logic [DEPTH_BIT-1:0] rd_addr_i,
   output logic [WIDTH-1:0]     rd_data_o
);
   localparam int D = 2 ** DEPTH_BIT;

   logic [WIDTH-1:0] mem_q [D];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   // Array write; no reset so the storage can map onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register holds its value until the next enabled read; the array
   // is sampled before the same-edge write, so a read at a colliding
   // address returns the old entry.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         rd_data_d = mem_q[rd_addr_i];
      end
   end

   // Output register clears on reset so the FIFO presents zero data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; optional usedw_o under SYNC_FIFO_USEDW_EN.
// Latency: rd_data_o updates on the edge that accepts a read; no fall-through when empty.
// Backpressure: writes while full are dropped unless a read is accepted on the same edge; reads while empty are ignored.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH_BIT = DEFAULT_DEPTH_BIT
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [WIDTH-1:0]   wr_data_i,
   input  logic               wr_req_i,
   input  logic               rd_req_i,
   output logic [WIDTH-1:0]   rd_data_o,
   output logic               full_o,
   output logic               empty_o
`ifdef SYNC_FIFO_USEDW_EN
  ,output logic [DEPTH_BIT:0] usedw_o
`endif
);
   localparam int D = 2 ** DEPTH_BIT;

   logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BIT:0]   count_q,  count_d;
   logic                 wr_acc;
   logic                 rd_acc;

   // Flags come from the registered count only.
   assign full_o  = (count_q == (DEPTH_BIT+1)'(D));
   assign empty_o = (count_q == '0);

   // Acceptance: a read frees a slot on the same edge, so a write to a full
   // FIFO is taken alongside it; an empty FIFO never forwards the write.
   assign rd_acc = rd_req_i && !empty_o;
   assign wr_acc = wr_req_i && (!full_o || rd_acc);

   // Next pointers and occupancy; pointers wrap naturally at D.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + DEPTH_BIT'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + DEPTH_BIT'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (DEPTH_BIT+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_BIT+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count state; reset discards all stored entries.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   sync_fifo_mem #(
      .WIDTH     (WIDTH),
      .DEPTH_BIT (DEPTH_BIT)
   ) u_mem (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data_o)
   );

`ifdef SYNC_FIFO_USEDW_EN
   assign usedw_o = count_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at WIDTH=4, DEPTH_BIT=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Expected values are fixed constants worked out by hand.
module tb_sync_fifo;
   localparam int WIDTH     = 4;
   localparam int DEPTH_BIT = 2;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic [WIDTH-1:0] wr_data_i;
   logic             wr_req_i;
   logic             rd_req_i;
   logic [WIDTH-1:0] rd_data_o;
   logic             full_o;
   logic             empty_o;
`ifdef SYNC_FIFO_USEDW_EN
   logic [DEPTH_BIT:0] usedw_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   sync_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH_BIT (DEPTH_BIT)
   ) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_data_i (wr_data_i),
      .wr_req_i  (wr_req_i),
      .rd_req_i  (rd_req_i),
      .rd_data_o (rd_data_o),
      .full_o    (full_o),
      .empty_o   (empty_o)
`ifdef SYNC_FIFO_USEDW_EN
     ,.usedw_o   (usedw_o)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_n_i   = 1'b0;
      wr_data_i = '0;
      wr_req_i  = 1'b0;
      rd_req_i  = 1'b0;

      // Reset state before any clock edge.
      #1;
      chk("rst_empty", 8'(empty_o), 8'd1);
      chk("rst_full",  8'(full_o),  8'd0);
      chk("rst_data",  8'(rd_data_o), 8'h0);
`ifdef SYNC_FIFO_USEDW_EN
      chk("rst_usedw", 8'(usedw_o), 8'd0);
`endif
      step();
      step();
      rst_n_i = 1'b1;

      // Fill with 0..3, then a dropped write of F.
      for (int i = 0; i < 4; i++) begin
         wr_data_i = 4'(i);
         wr_req_i  = 1'b1;
         step();
         if (i == 0) begin
            chk("fill1_empty", 8'(empty_o), 8'd0);
            chk("fill1_full",  8'(full_o),  8'd0);
         end
      end
      chk("fill4_full",  8'(full_o),  8'd1);
      chk("fill4_empty", 8'(empty_o), 8'd0);
`ifdef SYNC_FIFO_USEDW_EN
      chk("fill4_usedw", 8'(usedw_o), 8'd4);
`endif
      wr_data_i = 4'hF;
      step();
      chk("drop_full", 8'(full_o), 8'd1);
      wr_req_i = 1'b0;

      // Drain: 0,1,2,3 then an ignored fifth read.
      rd_req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_data", 8'(rd_data_o), 8'(i));
         if (i == 0) chk("drain1_full", 8'(full_o), 8'd0);
      end
      chk("drain_empty", 8'(empty_o), 8'd1);
      step();
      chk("rd_empty_hold", 8'(rd_data_o), 8'h3);
      chk("rd_empty_flag", 8'(empty_o), 8'd1);
      rd_req_i = 1'b0;

      // Interleaved write/read of 0..5; pointers wrap past D-1.
      for (int i = 0; i < 6; i++) begin
         wr_data_i = 4'(i);
         wr_req_i  = 1'b1;
         step();
         wr_req_i  = 1'b0;
         rd_req_i  = 1'b1;
         step();
         rd_req_i  = 1'b0;
         chk("wrap_data", 8'(rd_data_o), 8'(i));
      end
      chk("wrap_empty", 8'(empty_o), 8'd1);

      // Fill with 4..7, then simultaneous read/write of A while full.
      wr_req_i = 1'b1;
      for (int i = 4; i < 8; i++) begin
         wr_data_i = 4'(i);
         step();
      end
      wr_data_i = 4'hA;
      rd_req_i  = 1'b1;
      step();
      chk("full_rw_data", 8'(rd_data_o), 8'h4);
      chk("full_rw_full", 8'(full_o), 8'd1);
      wr_req_i = 1'b0;
      step(); chk("full_rw_rd5", 8'(rd_data_o), 8'h5);
      step(); chk("full_rw_rd6", 8'(rd_data_o), 8'h6);
      step(); chk("full_rw_rd7", 8'(rd_data_o), 8'h7);
      step(); chk("full_rw_rdA", 8'(rd_data_o), 8'hA);
      chk("full_rw_empty", 8'(empty_o), 8'd1);

      // Simultaneous read/write while empty: only the write is taken.
      wr_data_i = 4'h9;
      wr_req_i  = 1'b1;
      step();
      wr_req_i  = 1'b0;
      chk("empty_rw_hold",  8'(rd_data_o), 8'hA);
      chk("empty_rw_empty", 8'(empty_o), 8'd0);
      step();
      rd_req_i = 1'b0;
      chk("empty_rw_rd9", 8'(rd_data_o), 8'h9);
      chk("empty_rw_after", 8'(empty_o), 8'd1);

      // Write two entries, then reset between edges.
      wr_req_i  = 1'b1;
      wr_data_i = 4'h1;
      step();
      wr_data_i = 4'h2;
      step();
      wr_req_i  = 1'b0;
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_empty", 8'(empty_o), 8'd1);
      chk("mid_rst_full",  8'(full_o),  8'd0);
      chk("mid_rst_data",  8'(rd_data_o), 8'h0);
`ifdef SYNC_FIFO_USEDW_EN
      chk("mid_rst_usedw", 8'(usedw_o), 8'd0);
`endif
      #1;
      rst_n_i  = 1'b1;
      rd_req_i = 1'b1;
      step();
      rd_req_i = 1'b0;
      chk("post_rst_rd_data",  8'(rd_data_o), 8'h0);
      chk("post_rst_rd_empty", 8'(empty_o), 8'd1);

      // Storage works normally after reset.
      wr_data_i = 4'h5;
      wr_req_i  = 1'b1;
      step();
      wr_req_i  = 1'b0;
      chk("post_rst_wr_empty", 8'(empty_o), 8'd0);
      rd_req_i  = 1'b1;
      step();
      rd_req_i  = 1'b0;
      chk("post_rst_rd5", 8'(rd_data_o), 8'h5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
